// File: rtl/ssd_capture_if.sv
// Seven-segment bus between a multiplexed display driver (master) and ssd_capture (slave).
// SSD_CAPTURE_ERR_COUNT_EN adds the 8-bit undecodable-capture counter to the bus.
interface ssd_capture_if #(
   parameter int DIGITS = 8
);
   logic [6:0]          ssd_capture_port_ssd;
   logic                ssd_capture_port_dp;
   logic [DIGITS-1:0]   ssd_capture_port_an;
   logic [4*DIGITS-1:0] ssd_capture_port_value;
   logic [DIGITS-1:0]   ssd_capture_port_dps;
   logic [DIGITS-1:0]   ssd_capture_port_blank;
   logic                ssd_capture_port_frame_done;
   logic                ssd_capture_port_err;
`ifdef SSD_CAPTURE_ERR_COUNT_EN
   logic [7:0]          ssd_capture_port_err_cnt;

   modport master (
      output ssd_capture_port_ssd, ssd_capture_port_dp, ssd_capture_port_an,
      input  ssd_capture_port_value, ssd_capture_port_dps, ssd_capture_port_blank,
      input  ssd_capture_port_frame_done, ssd_capture_port_err, ssd_capture_port_err_cnt
   );
   modport slave (
      input  ssd_capture_port_ssd, ssd_capture_port_dp, ssd_capture_port_an,
      output ssd_capture_port_value, ssd_capture_port_dps, ssd_capture_port_blank,
      output ssd_capture_port_frame_done, ssd_capture_port_err, ssd_capture_port_err_cnt
   );
`else
   modport master (
      output ssd_capture_port_ssd, ssd_capture_port_dp, ssd_capture_port_an,
      input  ssd_capture_port_value, ssd_capture_port_dps, ssd_capture_port_blank,
      input  ssd_capture_port_frame_done, ssd_capture_port_err
   );
   modport slave (
      input  ssd_capture_port_ssd, ssd_capture_port_dp, ssd_capture_port_an,
      output ssd_capture_port_value, ssd_capture_port_dps, ssd_capture_port_blank,
      output ssd_capture_port_frame_done, ssd_capture_port_err
   );
`endif
endinterface

// File: rtl/ssd_capture.sv
// Loopback checker: samples a multiplexed active-low seven-segment display and rebuilds its digits.
// Optional macro SSD_CAPTURE_ERR_COUNT_EN adds a saturating count of undecodable captures.
module ssd_capture #(
   parameter int DIGITS = 8,
   parameter int SETTLE = 4
) (
   input logic          ssd_capture_port_clk,
   input logic          ssd_capture_port_rst,
   ssd_capture_if.slave bus
);
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, SETTLING, HOLD} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DIGITS-1:0]   an_q, an_p_q;
   logic [6:0]          ssd_q, ssd_p_q;
   logic                dp_q, dp_p_q;
   logic [4*DIGITS-1:0] value_q;
   logic [DIGITS-1:0]   dps_q, blank_q, seen_q;
   logic                frame_done_q, err_q;

   logic [DIGITS-1:0]   act, seen_upd;
   logic [IW-1:0]       idx;
   logic                an_valid, changed, capture, is_blank, bad, frame_full;
   logic [4:0]          dec;

   // Returns {decodable, nibble} for an active-low segment pattern.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      case (seg)
         7'h40: decode = 5'h10;  7'h79: decode = 5'h11;
         7'h24: decode = 5'h12;  7'h30: decode = 5'h13;
         7'h19: decode = 5'h14;  7'h12: decode = 5'h15;
         7'h02: decode = 5'h16;  7'h78: decode = 5'h17;
         7'h00: decode = 5'h18;  7'h10: decode = 5'h19;
         7'h08: decode = 5'h1A;  7'h03: decode = 5'h1B;
         7'h46: decode = 5'h1C;  7'h21: decode = 5'h1D;
         7'h06: decode = 5'h1E;  7'h0E: decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction

   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      act      = ~an_q;
      an_valid = (act != '0) && ((act & (act - DIGITS'(1))) == '0);
      changed  = {an_q, ssd_q, dp_q} != {an_p_q, ssd_p_q, dp_p_q};
      idx      = '0;
      for (int i = 0; i < DIGITS; i++)
         if (act[i]) idx = IW'(i);
   end

   always_ff @(posedge ssd_capture_port_clk or negedge ssd_capture_port_rst) begin
      // NOTE: registers update with non-blocking assignments so every flop sees pre-edge values.
      if (!ssd_capture_port_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE:
            if (an_valid) begin
               state_d = SETTLING;
               cnt_d   = CW'(SETTLE - 1);
            end
         SETTLING:
            if (changed) begin
               state_d = an_valid ? SETTLING : IDLE;
               cnt_d   = CW'(SETTLE - 1);
            end else if (cnt_q == '0) begin
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         HOLD:
            if (changed) begin
               state_d = an_valid ? SETTLING : IDLE;
               cnt_d   = CW'(SETTLE - 1);
            end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      capture    = (state_q == SETTLING) && !changed && (cnt_q == '0);
      dec        = decode(ssd_q);
      is_blank   = (ssd_q == 7'h7F);
      bad        = !is_blank && !dec[4];
      seen_upd   = seen_q | (DIGITS'(1) << idx);
      frame_full = &seen_upd;
   end

   always_ff @(posedge ssd_capture_port_clk or negedge ssd_capture_port_rst) begin
      if (!ssd_capture_port_rst) begin
         an_q         <= '0;
         ssd_q        <= '0;
         dp_q         <= 1'b0;
         an_p_q       <= '0;
         ssd_p_q      <= '0;
         dp_p_q       <= 1'b0;
         value_q      <= '0;
         dps_q        <= '0;
         blank_q      <= '0;
         seen_q       <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         an_q         <= bus.ssd_capture_port_an;
         ssd_q        <= bus.ssd_capture_port_ssd;
         dp_q         <= bus.ssd_capture_port_dp;
         an_p_q       <= an_q;
         ssd_p_q      <= ssd_q;
         dp_p_q       <= dp_q;
         frame_done_q <= capture && frame_full;
         if (capture) begin
            if (is_blank)
               value_q[4*int'(idx) +: 4] <= 4'h0;
            else if (!bad)
               value_q[4*int'(idx) +: 4] <= dec[3:0];
            dps_q[idx]   <= ~dp_q;
            blank_q[idx] <= is_blank;
            err_q        <= err_q | bad;
            // The completing capture is not carried into the next frame.
            seen_q       <= frame_full ? '0 : seen_upd;
         end
      end
   end

`ifdef SSD_CAPTURE_ERR_COUNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge ssd_capture_port_clk or negedge ssd_capture_port_rst) begin
      if (!ssd_capture_port_rst)
         err_cnt_q <= '0;
      else if (capture && bad && (err_cnt_q != 8'hFF))
         err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign bus.ssd_capture_port_err_cnt = err_cnt_q;
`endif

   assign bus.ssd_capture_port_value      = value_q;
   assign bus.ssd_capture_port_dps        = dps_q;
   assign bus.ssd_capture_port_blank      = blank_q;
   assign bus.ssd_capture_port_frame_done = frame_done_q;
   assign bus.ssd_capture_port_err        = err_q;
endmodule

// File: tb/tb_ssd_capture.sv
// Directed bench for ssd_capture (DIGITS=8, SETTLE=4) with hand-computed expectations.
// Build with SSD_CAPTURE_ERR_COUNT_EN defined to also exercise the error counter.
module tb_ssd_capture;
   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   int   fd_cnt   = 0;
   int   fd_before;

   logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   ssd_capture_if #(.DIGITS(8)) bus ();

   ssd_capture #(.DIGITS(8), .SETTLE(4)) dut (
      .ssd_capture_port_clk (clk),
      .ssd_capture_port_rst (rst_n),
      .bus                  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (bus.ssd_capture_port_frame_done === 1'b1) fd_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [7:0] an, input logic [6:0] seg, input logic dp, input int cyc);
      @(negedge clk);
      bus.ssd_capture_port_an  = an;
      bus.ssd_capture_port_ssd = seg;
      bus.ssd_capture_port_dp  = dp;
      repeat (cyc) @(negedge clk);
   endtask

   task automatic show(input int d, input logic [6:0] seg, input logic dp, input int cyc);
      drive(~(8'(1) << d), seg, dp, cyc);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.ssd_capture_port_an  = 8'hFF;
      bus.ssd_capture_port_ssd = 7'h7F;
      bus.ssd_capture_port_dp  = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle with no anode driven.
      drive(8'hFF, 7'h7F, 1'b1, 20);
      check("idle_value", 64'(bus.ssd_capture_port_value), 64'h0);
      check("idle_dps",   64'(bus.ssd_capture_port_dps), 64'h0);
      check("idle_blank", 64'(bus.ssd_capture_port_blank), 64'h0);
      check("idle_err",   64'(bus.ssd_capture_port_err), 64'h0);
      check("idle_fd",    64'(fd_cnt), 64'd0);

      // Full scan 0..7; frame_done only on digit 7.
      for (int d = 0; d < 7; d++) show(d, seg_tbl[d], 1'b1, 10);
      check("scan_no_early_fd", 64'(fd_cnt), 64'd0);
      show(7, seg_tbl[7], 1'b1, 10);
      check("scan_value", 64'(bus.ssd_capture_port_value), 64'h76543210);
      check("scan_fd",    64'(fd_cnt), 64'd1);
      check("scan_err",   64'(bus.ssd_capture_port_err), 64'h0);
      check("scan_dps",   64'(bus.ssd_capture_port_dps), 64'h0);

      // Short dwell on digit 2, then digit 3 captured at SETTLE+2 cycles.
      show(2, 7'h00, 1'b1, 2);
      @(negedge clk);
      bus.ssd_capture_port_an  = ~8'(1 << 3);
      bus.ssd_capture_port_ssd = 7'h10;
      repeat (5) @(negedge clk);
      check("lat_before", 64'(bus.ssd_capture_port_value[15:12]), 64'h3);
      @(negedge clk);
      check("lat_at",     64'(bus.ssd_capture_port_value[15:12]), 64'h9);
      check("short_slot2", 64'(bus.ssd_capture_port_value[11:8]), 64'h2);
      repeat (4) @(negedge clk);

      // Blank digit with decimal point lit.
      show(5, 7'h7F, 1'b0, 10);
      check("blank_mask",  64'(bus.ssd_capture_port_blank), 64'h20);
      check("blank_nib",   64'(bus.ssd_capture_port_value[23:20]), 64'h0);
      check("blank_dps",   64'(bus.ssd_capture_port_dps), 64'h20);

      // Undecodable pattern.
      show(1, 7'h55, 1'b1, 10);
      check("bad_err",   64'(bus.ssd_capture_port_err), 64'h1);
      check("bad_value", 64'(bus.ssd_capture_port_value), 64'h76049210);
      check("bad_no_fd", 64'(fd_cnt), 64'd1);
`ifdef SSD_CAPTURE_ERR_COUNT_EN
      check("errcnt_one", 64'(bus.ssd_capture_port_err_cnt), 64'd1);
`endif

      // Two anodes low: no digit.
      drive(8'hFC, 7'h00, 1'b0, 10);
      check("multi_an_value", 64'(bus.ssd_capture_port_value), 64'h76049210);
      check("multi_an_dps",   64'(bus.ssd_capture_port_dps), 64'h20);

`ifdef SSD_CAPTURE_ERR_COUNT_EN
      for (int k = 0; k < 300; k++) show((k % 2 == 0) ? 2 : 1, 7'h55, 1'b1, 7);
      check("errcnt_sat", 64'(bus.ssd_capture_port_err_cnt), 64'd255);
      check("errcnt_val", 64'(bus.ssd_capture_port_value), 64'h76049210);
`endif

      // Reset mid-SETTLING.
      show(0, 7'h0E, 1'b1, 2);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_value", 64'(bus.ssd_capture_port_value), 64'h0);
      check("rst_dps",   64'(bus.ssd_capture_port_dps), 64'h0);
      check("rst_blank", 64'(bus.ssd_capture_port_blank), 64'h0);
      check("rst_err",   64'(bus.ssd_capture_port_err), 64'h0);
      check("rst_fd",    64'(bus.ssd_capture_port_frame_done), 64'h0);
`ifdef SSD_CAPTURE_ERR_COUNT_EN
      check("rst_errcnt", 64'(bus.ssd_capture_port_err_cnt), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Seen-mask must be clear: digits 0,2,4,6,7 alone do not finish a frame.
      fd_before = fd_cnt;
      for (int d = 0; d < 8; d += 2) show(d, seg_tbl[d + 8], 1'b1, 10);
      show(7, seg_tbl[15], 1'b1, 10);
      check("post_rst_no_fd", 64'(fd_cnt), 64'(fd_before));
      for (int d = 1; d < 7; d += 2) show(d, seg_tbl[d + 8], 1'b1, 10);
      check("post_rst_fd",    64'(fd_cnt), 64'(fd_before + 1));
      check("post_rst_value", 64'(bus.ssd_capture_port_value), 64'hFEDCBA98);
      check("post_rst_err",   64'(bus.ssd_capture_port_err), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
